intdiv_radix2: RTL and testbench
================================

// Module: intdiv_radix2
// PURPOSE
//  Iterative radix-2 restoring integer divider for RV DIV/DIVU/REM/REMU (+W forms when XLEN=64) in the Execute stage.
//  Feeds the hazard unit: DivBusyE holds Execute (and upstream stages) stalled while the divide runs.
//  Honours StallM and FlushE from the hazard unit. The result is presented in E for the normal E->M pipeline register.
// PARAMETERS
//  XLEN    64   datapath width (32 or 64); W-ops are legal only when XLEN=64
// PORTS
//  clk              in   1     clock
//  reset            in   1     synchronous, active-high reset
//  IntDivE          in   1     E-stage instruction is an integer divide/remainder
//  Funct3E          in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//  W64E             in   1     word op (DIVW etc.), operands and result use bits [31:0]
//  ForwardedSrcAE   in   XLEN  dividend
//  ForwardedSrcBE   in   XLEN  divisor
//  StallM           in   1     from hazard unit; M cannot accept a new instruction
//  FlushE           in   1     from hazard unit; kill the E-stage instruction
//  DivBusyE         out  1     to hazard unit; divide in progress
//  DivResultE       out  XLEN  quotient or remainder; valid in DONE
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, internal regs=0; DivBusyE=0, DivResultE=0.
//  - DivStartE = IntDivE & (state==IDLE) & ~StallM & ~FlushE.
//  - DivBusyE  = DivStartE | (state==BUSY). Combinational; no dependence on DivBusyE outputs inside the hazard unit.
//  - States and transitions:
//    IDLE -> BUSY on DivStartE with divisor!=0. Captures Funct3E/W64E, |A|, |B|, sign flags. Counter=N-1.
//    IDLE -> DONE on DivStartE with divisor==0 (DivBusyE high for that cycle only).
//    BUSY: one quotient bit per cycle (shift-subtract). Counter decrements. -> DONE when counter==0.
//    DONE -> IDLE when ~StallM (the instruction leaves E). Holds DONE and a stable DivResultE while StallM=1.
//  - FlushE in any state -> IDLE next cycle, with no result. FlushE has priority over every other transition.
//  - reset mid-operation -> IDLE next cycle.
//  - N = 32 when W64E (or XLEN=32), else XLEN.
//    Total DivBusyE cycles = N+1 (start + N iterations).
//    Result is available the cycle after the last iteration.
//  - Operand prep:
//    Signed = ~Funct3E[0].
//    For W64E, operands are bits [31:0], sign-extended if signed and zero-extended otherwise.
//    Magnitude = two's-complement abs when signed and negative.
//  - Result fixup (DONE, combinational from regs):
//    Quotient is negated if signed & (signA ^ signB).
//    Remainder is negated if signed & signA.
//    Funct3E[1] selects the remainder.
//    For W64E, the result is bits [31:0] sign-extended to 64 (DIVUW/REMUW included, per ISA).
//  - Divide by zero: quotient = all ones, remainder = dividend (W: sign-extended low 32 bits).
//  - Signed overflow (MIN / -1) needs no special case: the algorithm yields Q=MIN, R=0.
//  - IntDivE arriving while state!=IDLE is ignored. Operands are only sampled on DivStartE.
//  - DivResultE = 0 outside DONE.
// TESTING
//  - Reset mid-BUSY: reset at iteration 10 -> next cycle DivBusyE=0, state IDLE; a new DIV then completes normally.
//  - XLEN=64 DIV 100/7 -> DivBusyE high 65 cycles, then DivResultE=14. REM 100/7 -> 2; REM -100/7 -> -2.
//  - DIVU 0xFFFF_FFFF_FFFF_FFFF/2 -> 0x7FFF_FFFF_FFFF_FFFF.
//    DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
//  - Divide by zero:
//    DIV 5/0 -> DivBusyE high 1 cycle, result 0xFFFF_FFFF_FFFF_FFFF.
//    REMUW 0x1_8000_0001/0 -> 0xFFFF_FFFF_8000_0001.
//  - DIVW 0x0000_0000_FFFF_FFF6/3 -> 33 busy cycles, result 0xFFFF_FFFF_FFFF_FFFD.
//  - Hold and flush:
//    StallM held 3 cycles in DONE -> DivResultE stable; IDLE on the first ~StallM.
//    FlushE at iteration 20 -> IDLE next cycle, DivBusyE=0.

Source files
------------

// File: rtl/intdiv_radix2.sv
`default_nettype none
// ============================================================================
// Module   : intdiv_radix2
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (+W).
// Revision : 1.0
// ============================================================================
module intdiv_radix2 #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IntDivE,
    input  logic [2:0]      Funct3E,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            StallM,
    input  logic            FlushE,
    output logic            DivBusyE,
    output logic [XLEN-1:0] DivResultE
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem, r_quo, r_div;
    logic            r_negq, r_negr, r_selrem, r_w64;

    logic            w_w64, w_signed, w_sa, w_sb, w_divzero, w_start;
    logic [XLEN-1:0] w_a, w_b, w_maga, w_magb;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] w_q, w_r, w_sel, w_res;
    logic            w_unused;

    assign w_unused = Funct3E[2];

    // Operand preparation: word ops take the low 32 bits, extended per signedness
    always_comb begin
        w_w64    = W64E & (XLEN == 64);
        w_signed = ~Funct3E[0];
        if (w_w64) begin
            w_a = w_signed ? XLEN'($signed(ForwardedSrcAE[31:0])) : XLEN'(ForwardedSrcAE[31:0]);
            w_b = w_signed ? XLEN'($signed(ForwardedSrcBE[31:0])) : XLEN'(ForwardedSrcBE[31:0]);
        end else begin
            w_a = ForwardedSrcAE;
            w_b = ForwardedSrcBE;
        end
        w_sa      = w_signed & w_a[XLEN-1];
        w_sb      = w_signed & w_b[XLEN-1];
        w_maga    = w_sa ? -w_a : w_a;
        w_magb    = w_sb ? -w_b : w_b;
        w_divzero = (w_b == '0);
    end

    assign w_start  = IntDivE & (r_state == S_IDLE) & ~StallM & ~FlushE;
    assign DivBusyE = w_start | (r_state == S_BUSY);

    // One restoring shift-subtract step; the MSB of the difference is the borrow
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = w_divzero ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  if (!StallM) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (FlushE) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_selrem <= 1'b0;
            r_w64    <= 1'b0;
        end else if (w_start) begin
            r_selrem <= Funct3E[1];
            r_w64    <= w_w64;
            r_div    <= w_magb;
            if (w_divzero) begin
                // All-ones quotient and untouched dividend fall out of the normal fixup
                r_cnt  <= '0;
                r_quo  <= '1;
                r_rem  <= w_a;
                r_negq <= 1'b0;
                r_negr <= 1'b0;
            end else begin
                r_cnt  <= w_w64 ? CW'(31) : CW'(XLEN - 1);
                r_quo  <= w_w64 ? (w_maga << 32) : w_maga;
                r_rem  <= '0;
                r_negq <= w_sa ^ w_sb;
                r_negr <= w_sa;
            end
        end else if ((r_state == S_BUSY) && !FlushE) begin
            r_cnt <= r_cnt - 1'b1;
            if (!w_diff[XLEN]) begin
                r_rem <= w_diff[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_q   = r_negq ? -r_quo : r_quo;
        w_r   = r_negr ? -r_rem : r_rem;
        w_sel = r_selrem ? w_r : w_q;
        w_res = r_w64 ? XLEN'($signed(w_sel[31:0])) : w_sel;
    end

    assign DivResultE = (r_state == S_DONE) ? w_res : '0;

endmodule
`default_nettype wire

// File: tb/tb_intdiv_radix2.sv
`default_nettype none
// ============================================================================
// Module   : tb_intdiv_radix2
// Brief    : Directed self-checking bench for intdiv_radix2 (XLEN=64).
// Revision : 1.0
// ============================================================================
module tb_intdiv_radix2;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            IntDivE;
    logic [2:0]      Funct3E;
    logic            W64E;
    logic [XLEN-1:0] ForwardedSrcAE, ForwardedSrcBE;
    logic            StallM, FlushE;
    logic            DivBusyE;
    logic [XLEN-1:0] DivResultE;

    int n_cmp = 0;
    int n_err = 0;

    intdiv_radix2 #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .IntDivE       (IntDivE),
        .Funct3E       (Funct3E),
        .W64E          (W64E),
        .ForwardedSrcAE(ForwardedSrcAE),
        .ForwardedSrcBE(ForwardedSrcBE),
        .StallM        (StallM),
        .FlushE        (FlushE),
        .DivBusyE      (DivBusyE),
        .DivResultE    (DivResultE)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Issue one divide, count busy cycles, optionally hold it in DONE with StallM
    task automatic run_div(input string tag, input logic [2:0] f3, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input int exp_busy, input logic [63:0] exp_res, input int stall_cyc);
        int busy;
        busy = 0;
        @(posedge clk); #1;
        IntDivE = 1'b1; Funct3E = f3; W64E = w;
        ForwardedSrcAE = a; ForwardedSrcBE = b;
        @(negedge clk);
        while (DivBusyE && busy < 200) begin
            busy++;
            @(posedge clk); #1;
            IntDivE = 1'b0;
            ForwardedSrcAE = '0; ForwardedSrcBE = '0;
            @(negedge clk);
        end
        IntDivE = 1'b0;
        check_val({tag, "_busy"}, 64'(busy), 64'(exp_busy));
        check_val({tag, "_res"}, DivResultE, exp_res);
        if (stall_cyc > 0) begin
            StallM = 1'b1;
            for (int k = 0; k < stall_cyc; k++) begin
                @(posedge clk); @(negedge clk);
                check_val({tag, "_hold"}, DivResultE, exp_res);
            end
            StallM = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        check_val({tag, "_idle"}, DivResultE, 64'h0);
    endtask

    initial begin
        reset = 1'b1; IntDivE = 1'b0; Funct3E = 3'b100; W64E = 1'b0;
        ForwardedSrcAE = '0; ForwardedSrcBE = '0; StallM = 1'b0; FlushE = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 64'(DivBusyE), 64'h0);
        check_val("rst_res", DivResultE, 64'h0);
        reset = 1'b0;

        run_div("div_100_7",   3'b100, 1'b0, 64'd100, 64'd7, 65, 64'd14, 0);
        run_div("rem_100_7",   3'b110, 1'b0, 64'd100, 64'd7, 65, 64'd2, 0);
        run_div("rem_m100_7",  3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_div("div_m100_7",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2, 0);
        run_div("remu_100_7",  3'b111, 1'b0, 64'd100, 64'd7, 65, 64'd2, 0);
        run_div("divu_max_2",  3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'h7FFF_FFFF_FFFF_FFFF, 0);
        run_div("div_min_m1",  3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'h8000_0000_0000_0000, 0);
        run_div("rem_min_m1",  3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'h0, 0);
        run_div("div_5_0",     3'b100, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_div("remuw_x_0",   3'b111, 1'b1, 64'h0000_0001_8000_0001, 64'd0, 1, 64'hFFFF_FFFF_8000_0001, 0);
        run_div("divw_m10_3",  3'b100, 1'b1, 64'h0000_0000_FFFF_FFF6, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_div("remw_m7_2",   3'b110, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_div("divuw_upper", 3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h0000_0009_0000_0010, 33, 64'h0000_0000_0FFF_FFFF, 0);
        run_div("stall_hold",  3'b100, 1'b0, 64'd100, 64'd7, 65, 64'd14, 3);

        // Reset around iteration 10 of a running divide
        @(posedge clk); #1;
        IntDivE = 1'b1; Funct3E = 3'b100; W64E = 1'b0;
        ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        @(posedge clk); #1;
        IntDivE = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rstmid_busy", 64'(DivBusyE), 64'h0);
        check_val("rstmid_res", DivResultE, 64'h0);
        reset = 1'b0;
        run_div("after_rst", 3'b100, 1'b0, 64'd1000, 64'd10, 65, 64'd100, 0);

        // Flush around iteration 20
        @(posedge clk); #1;
        IntDivE = 1'b1; Funct3E = 3'b100; W64E = 1'b0;
        ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        @(posedge clk); #1;
        IntDivE = 1'b0;
        repeat (19) @(posedge clk);
        #1 FlushE = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("flush_busy", 64'(DivBusyE), 64'h0);
        check_val("flush_res", DivResultE, 64'h0);
        FlushE = 1'b0;
        repeat (3) @(negedge clk);
        check_val("flush_stay", DivResultE, 64'h0);
        run_div("after_flush", 3'b111, 1'b0, 64'd1000, 64'd7, 65, 64'd6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
